// File: rtl/bsg_iterative_divider_if.sv
// Request/result bundle for the iterative divider.
// Request side is valid/ready, result side is valid/yumi.
interface bsg_iterative_divider_if #(
  parameter int width_p = 8
);
  logic                   v_i;
  logic [2*width_p-1:0]   dividend_i;
  logic [width_p-1:0]     divisor_i;
  logic                   ready_o;
  logic                   v_o;
  logic [width_p-1:0]     quotient_o;
  logic [width_p-1:0]     remainder_o;
  logic                   overflow_o;
  logic                   yumi_i;

  modport master (
    output v_i,
    output dividend_i,
    output divisor_i,
    input  ready_o,
    input  v_o,
    input  quotient_o,
    input  remainder_o,
    input  overflow_o,
    output yumi_i
  );

  modport slave (
    input  v_i,
    input  dividend_i,
    input  divisor_i,
    output ready_o,
    output v_o,
    output quotient_o,
    output remainder_o,
    output overflow_o,
    input  yumi_i
  );
endinterface

// File: rtl/bsg_iterative_divider.sv
// Restoring unsigned divider, 2w/w -> w quotient + w remainder.
// Define BSG_ITERATIVE_DIVIDER_RADIX4_EN for two quotient bits per cycle.
module bsg_iterative_divider #(
  parameter int width_p = 8
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_iterative_divider_if.slave io
);

`ifdef BSG_ITERATIVE_DIVIDER_RADIX4_EN
  localparam int STEPS_LP = width_p / 2;
  if ((width_p % 2) != 0) begin : g_odd_width
    $error("radix-4 divider needs an even width_p");
  end
`else
  localparam int STEPS_LP = width_p;
`endif
  localparam int CW_LP = $clog2(STEPS_LP + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [CW_LP-1:0]   r_cnt;
  logic [width_p-1:0] r_rem;
  logic [width_p-1:0] r_dvd;
  logic [width_p-1:0] r_dvs;
  logic [width_p-1:0] r_quot;
  logic [width_p-1:0] r_remo;
  logic               r_ov;

  logic               w_ready;
  logic               w_v;
  logic               w_accept;
  logic               w_ovf;
  logic               w_last;
  logic [width_p:0]   w_t1;
  logic [width_p:0]   w_d1;
  logic [width_p-1:0] w_r1;
  logic [width_p-1:0] w_rem_nxt;
  logic [width_p-1:0] w_dvd_nxt;

  assign w_accept = io.v_i & w_ready;
  assign w_ovf    = io.dividend_i[2*width_p-1:width_p]
                    >= io.divisor_i;
  assign w_last   = (r_cnt == CW_LP'(STEPS_LP - 1));

  // One restoring step: shift in next dividend bit, trial subtract.
  // r_dvd shifts the dividend out the top and the quotient in the bottom.
  assign w_t1 = {r_rem, r_dvd[width_p-1]};
  assign w_d1 = w_t1 - {1'b0, r_dvs};
  assign w_r1 = w_d1[width_p] ? w_t1[width_p-1:0]
                              : w_d1[width_p-1:0];

`ifdef BSG_ITERATIVE_DIVIDER_RADIX4_EN
  logic [width_p:0] w_t2;
  logic [width_p:0] w_d2;

  // Second chained step in the same cycle.
  assign w_t2 = {w_r1, r_dvd[width_p-2]};
  assign w_d2 = w_t2 - {1'b0, r_dvs};
  assign w_rem_nxt = w_d2[width_p] ? w_t2[width_p-1:0]
                                   : w_d2[width_p-1:0];
  assign w_dvd_nxt = {r_dvd[width_p-3:0],
                      ~w_d1[width_p], ~w_d2[width_p]};
`else
  assign w_rem_nxt = w_r1;
  assign w_dvd_nxt = {r_dvd[width_p-2:0], ~w_d1[width_p]};
`endif

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_ovf ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (io.yumi_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    w_ready = 1'b0;
    w_v     = 1'b0;
    unique case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_DONE:  w_v     = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_ov   <= 1'b0;
    end else if (w_accept) begin
      if (w_ovf) begin
        r_quot <= '1;
        r_remo <= io.dividend_i[width_p-1:0];
        r_ov   <= 1'b1;
      end else begin
        r_rem <= io.dividend_i[2*width_p-1:width_p];
        r_dvd <= io.dividend_i[width_p-1:0];
        r_dvs <= io.divisor_i;
        r_cnt <= '0;
      end
    end else if (r_state == S_BUSY) begin
      r_rem <= w_rem_nxt;
      r_dvd <= w_dvd_nxt;
      r_cnt <= r_cnt + CW_LP'(1);
      if (w_last) begin
        r_quot <= w_dvd_nxt;
        r_remo <= w_rem_nxt;
        r_ov   <= 1'b0;
      end
    end
  end

  assign io.ready_o     = w_ready;
  assign io.v_o         = w_v;
  assign io.quotient_o  = r_quot;
  assign io.remainder_o = r_remo;
  assign io.overflow_o  = r_ov;

endmodule

// File: tb/tb_bsg_iterative_divider.sv
// Directed + random bench for bsg_iterative_divider.
// Expected results come from a behavioural model through a scoreboard queue.
module tb_bsg_iterative_divider;
  localparam int W = 8;
`ifdef BSG_ITERATIVE_DIVIDER_RADIX4_EN
  localparam int LAT_N = W / 2 + 1;
`else
  localparam int LAT_N = W + 1;
`endif

  typedef struct {
    int q;
    int r;
    int ov;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bsg_iterative_divider_if #(.width_p(W)) dif ();

  bsg_iterative_divider #(.width_p(W)) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .io       (dif.slave)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_exp(int dvd, int dvs);
    exp_t e;
    if ((dvd >> W) >= dvs) begin
      e.q   = (1 << W) - 1;
      e.r   = dvd & ((1 << W) - 1);
      e.ov  = 1;
      e.lat = 1;
    end else begin
      e.q   = dvd / dvs;
      e.r   = dvd % dvs;
      e.ov  = 0;
      e.lat = LAT_N;
    end
    sb.push_back(e);
  endtask

  task automatic run(int dvd, int dvs, int hold, bit pulse);
    int   lat;
    exp_t e;
    @(negedge clk);
    chk("ready_idle", 32'(dif.ready_o), 32'd1);
    dif.v_i        = 1'b1;
    dif.dividend_i = dvd[2*W-1:0];
    dif.divisor_i  = dvs[W-1:0];
    push_exp(dvd, dvs);
    @(posedge clk);
    @(negedge clk);
    dif.v_i        = 1'b0;
    dif.dividend_i = 16'($urandom);
    dif.divisor_i  = 8'($urandom);
    lat = 1;
    while (!dif.v_o && lat < 64) begin
      if (pulse && lat == 3) begin
        chk("busy_ready", 32'(dif.ready_o), 32'd0);
        dif.v_i        = 1'b1;
        dif.dividend_i = 16'd50;
        dif.divisor_i  = 8'd5;
      end
      @(posedge clk);
      @(negedge clk);
      dif.v_i = 1'b0;
      lat++;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("quot", 32'(dif.quotient_o), 32'(e.q));
    chk("rem", 32'(dif.remainder_o), 32'(e.r));
    chk("ovf", 32'(dif.overflow_o), 32'(e.ov));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_v", 32'(dif.v_o), 32'd1);
      chk("hold_q", 32'(dif.quotient_o), 32'(e.q));
      chk("hold_r", 32'(dif.remainder_o), 32'(e.r));
    end
    dif.yumi_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.yumi_i = 1'b0;
    chk("v_after_yumi", 32'(dif.v_o), 32'd0);
    chk("ready_after_yumi", 32'(dif.ready_o), 32'd1);
  endtask

  initial begin
    rst_n          = 1'b1;
    dif.v_i        = 1'b0;
    dif.dividend_i = '0;
    dif.divisor_i  = '0;
    dif.yumi_i     = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_v", 32'(dif.v_o), 32'd0);
    chk("rst_q", 32'(dif.quotient_o), 32'd0);
    chk("rst_r", 32'(dif.remainder_o), 32'd0);
    chk("rst_ov", 32'(dif.overflow_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(dif.ready_o), 32'd1);

    run(391, 17, 0, 1'b0);
    run(32'hFEFF, 32'hFF, 0, 1'b0);
    run(32'h1234, 32'h12, 0, 1'b0);
    run(5, 0, 0, 1'b0);
    run(1000, 7, 5, 1'b1);
    repeat (12) begin
      @(negedge clk);
      chk("no_extra_v", 32'(dif.v_o), 32'd0);
    end

    // Abort an operation in flight with reset.
    @(negedge clk);
    dif.v_i        = 1'b1;
    dif.dividend_i = 16'd1000;
    dif.divisor_i  = 8'd7;
    @(posedge clk);
    @(negedge clk);
    dif.v_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_v", 32'(dif.v_o), 32'd0);
    chk("abort_q", 32'(dif.quotient_o), 32'd0);
    chk("abort_r", 32'(dif.remainder_o), 32'd0);
    chk("abort_ov", 32'(dif.overflow_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_v", 32'(dif.v_o), 32'd0);
    end
    run(100, 10, 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(1, 255));
      if (k % 4 == 0) a = a & 16'h00FF;
      run(a, b, k % 3, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
